// File: rtl/regfile_ctx_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_ctx_if
//  Description : Register-file port plus save (out) and restore (in) streams
//                shared between the context save/restore engine and its
//                environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_ctx_if;
   // register-file read port (data is combinational from the selects)
   logic [2:0]  read1RegSel;
   logic [2:0]  read2RegSel;
   logic [15:0] read1Data;
   logic [15:0] read2Data;
   logic        rf_err;
   // register-file write port
   logic [2:0]  writeRegSel;
   logic [15:0] writeData;
   logic        writeEn;
   // save stream
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   // restore stream
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;

   modport master (
      output read1RegSel, read2RegSel, writeRegSel, writeData, writeEn,
             out_valid, out_data, in_ready,
      input  read1Data, read2Data, rf_err, out_ready, in_valid, in_data
   );

   modport slave (
      input  read1RegSel, read2RegSel, writeRegSel, writeData, writeEn,
             out_valid, out_data, in_ready,
      output read1Data, read2Data, rf_err, out_ready, in_valid, in_data
   );
endinterface
`default_nettype wire

// File: rtl/regfile_ctx.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_ctx
//  Description : Saves registers 0..NREGS-1 as 32-bit pairs onto an output
//                stream, or restores them one 16-bit word per beat from an
//                input stream. A register-file error aborts the operation
//                and raises a sticky err flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_ctx #(
   parameter int NREGS = 8
) (
   input  wire logic     clk,
   input  wire logic     rst,
   input  wire logic     save_start,
   input  wire logic     restore_start,
   output logic          busy,
   output logic          done,
   output logic          err,
   regfile_ctx_if.master bus
);

   localparam logic [2:0] LAST_BEAT = 3'(NREGS / 2 - 1);
   localparam logic [2:0] LAST_REG  = 3'(NREGS - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      S_FETCH = 3'd1,
      S_SEND  = 3'd2,
      R_RECV  = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [2:0]  k;
   logic [2:0]  k_nxt;
   logic [31:0] out_word;
   logic        load_out;
   logic        err_flag;
   logic        err_set;
   logic        err_clr;

   // State, beat index, captured save word and sticky error flag
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         k        <= 3'd0;
         out_word <= 32'd0;
         err_flag <= 1'b0;
      end else begin
         state <= state_nxt;
         k     <= k_nxt;
         if (load_out) begin
            out_word <= {bus.read2Data, bus.read1Data};
         end
         if (err_set) begin
            err_flag <= 1'b1;
         end else if (err_clr) begin
            err_flag <= 1'b0;
         end
      end
   end

   // Next-state decode and all outputs; outputs are forced low while rst is asserted
   always_comb begin
      state_nxt       = state;
      k_nxt           = k;
      load_out        = 1'b0;
      err_set         = 1'b0;
      err_clr         = 1'b0;
      busy            = 1'b0;
      done            = 1'b0;
      err             = 1'b0;
      bus.read1RegSel = 3'd0;
      bus.read2RegSel = 3'd0;
      bus.writeRegSel = 3'd0;
      bus.writeData   = 16'd0;
      bus.writeEn     = 1'b0;
      bus.out_valid   = 1'b0;
      bus.out_data    = 32'd0;
      bus.in_ready    = 1'b0;

      case (state)
         IDLE: begin
            // save has priority; a simultaneous restore request is dropped
            if (save_start) begin
               k_nxt     = 3'd0;
               state_nxt = S_FETCH;
               err_clr   = 1'b1;
            end else if (restore_start) begin
               k_nxt     = 3'd0;
               state_nxt = R_RECV;
               err_clr   = 1'b1;
            end
         end
         S_FETCH: begin
            if (bus.rf_err) begin
               err_set   = 1'b1;
               state_nxt = DONE;
            end else begin
               load_out  = 1'b1;
               state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            if (bus.rf_err) begin
               err_set   = 1'b1;
               state_nxt = DONE;
            end else if (bus.out_ready) begin
               if (k == LAST_BEAT) begin
                  state_nxt = DONE;
               end else begin
                  k_nxt     = k + 3'd1;
                  state_nxt = S_FETCH;
               end
            end
         end
         R_RECV: begin
            if (bus.rf_err) begin
               err_set   = 1'b1;
               state_nxt = DONE;
            end else if (bus.in_valid) begin
               if (k == LAST_REG) begin
                  state_nxt = DONE;
               end else begin
                  k_nxt = k + 3'd1;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (rst) begin
         busy         = (state != IDLE);
         done         = (state == DONE);
         err          = err_flag;
         bus.out_data = out_word;
         if (state == S_FETCH || state == S_SEND) begin
            bus.read1RegSel = {k[1:0], 1'b0};
            bus.read2RegSel = {k[1:0], 1'b1};
         end
         // an rf_err cycle must not complete any stream handshake
         bus.out_valid = (state == S_SEND) && !bus.rf_err;
         bus.in_ready  = (state == R_RECV) && !bus.rf_err;
         if (bus.in_ready && bus.in_valid) begin
            bus.writeEn     = 1'b1;
            bus.writeRegSel = k;
            bus.writeData   = bus.in_data;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_regfile_ctx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_ctx
//  Description : Self-checking bench for regfile_ctx: a behavioural register
//                file plus a transaction-level model of the save and restore
//                operations, with random and directed stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_ctx;

   localparam int NREGS = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic save_start = 1'b0;
   logic restore_start = 1'b0;
   logic busy;
   logic done;
   logic err;

   int n_chk  = 0;
   int n_pass = 0;

   // register file contents, preload values and the bench's model of them
   logic [15:0] rf[NREGS];
   logic [15:0] load_vals[NREGS];
   logic        load_en = 1'b0;
   logic [15:0] mdl[NREGS];

   regfile_ctx_if bus();

   regfile_ctx #(.NREGS(NREGS)) dut (
      .clk           (clk),
      .rst           (rst),
      .save_start    (save_start),
      .restore_start (restore_start),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .bus           (bus)
   );

   always #5 clk = ~clk;

   assign bus.read1Data = rf[bus.read1RegSel];
   assign bus.read2Data = rf[bus.read2RegSel];

   // register file storage: bench preload or DUT write port
   always @(posedge clk) begin
      if (load_en) begin
         for (int i = 0; i < NREGS; i++) rf[i] <= load_vals[i];
      end else if (bus.writeEn) begin
         rf[bus.writeRegSel] <= bus.writeData;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic preload(input bit seq);
      @(negedge clk);
      for (int i = 0; i < NREGS; i++) begin
         load_vals[i] = seq ? 16'(32'h1000 + i) : 16'($urandom);
         mdl[i]       = load_vals[i];
      end
      load_en = 1'b1;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   // One save or restore operation. Cycle 0 is the start cycle. Each beat is
   // checked against the model; protocol rule breaks are counted in viol.
   task automatic run_op(input bit do_save, input bit do_rest, input int pct,
                         input int err_cyc, input bit seq, input int stall_len,
                         output int nbeats, output int done_cyc, output int last_hs,
                         output int viol, output logic err1);
      logic [15:0] snap[NREGS];
      logic [31:0] prev_data;
      bit          prev_stall;
      int          stalls;
      for (int i = 0; i < NREGS; i++) snap[i] = mdl[i];
      nbeats = 0; done_cyc = -1; last_hs = -100; viol = 0; err1 = 1'bx;
      prev_stall = 0; prev_data = 32'd0; stalls = 0;
      @(negedge clk);
      save_start = do_save; restore_start = do_rest;
      bus.out_ready = 1'b0; bus.in_valid = 1'b0; bus.in_data = 16'd0; bus.rf_err = 1'b0;
      #1;
      if (busy || done) viol++;
      for (int cyc = 1; cyc < 200 && done_cyc < 0; cyc++) begin
         @(negedge clk);
         // stray start requests during the operation must be ignored
         save_start    = ($urandom_range(7) == 0);
         restore_start = ($urandom_range(7) == 0);
         bus.out_ready = ($urandom_range(99) < pct);
         if (do_save && nbeats == 1 && stalls < stall_len) bus.out_ready = 1'b0;
         bus.in_valid  = ($urandom_range(99) < pct);
         bus.in_data   = seq ? 16'(32'hA000 + nbeats) : 16'($urandom);
         bus.rf_err    = (cyc == err_cyc);
         #1;
         if (cyc == 1) err1 = err;
         if (!busy) viol++;
         if (!bus.writeEn && (bus.writeRegSel != 3'd0 || bus.writeData != 16'd0)) viol++;
         if (bus.rf_err && (bus.out_valid || bus.in_ready || bus.writeEn)) viol++;
         if (do_save) begin
            if (bus.in_ready || bus.writeEn) viol++;
            if (prev_stall && !(bus.out_valid && bus.out_data == prev_data)) viol++;
            if (bus.out_valid) begin
               if (bus.read1RegSel != 3'(2 * nbeats) || bus.read2RegSel != 3'(2 * nbeats + 1)) viol++;
               if (!bus.out_ready && nbeats == 1) stalls++;
            end
            if (bus.out_valid && bus.out_ready) begin
               if (nbeats < NREGS / 2)
                  check("save_beat", bus.out_data, {snap[2 * nbeats + 1], snap[2 * nbeats]});
               else
                  viol++;
               if (cyc - last_hs < 2) viol++;
               last_hs = cyc;
               nbeats++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
         end else begin
            if (bus.out_valid) viol++;
            if (bus.writeEn != (bus.in_valid && bus.in_ready)) viol++;
            if (bus.in_valid && bus.in_ready) begin
               if (nbeats < NREGS) begin
                  check("wr_sel", 32'(bus.writeRegSel), 32'(nbeats));
                  check("wr_data", 32'(bus.writeData), 32'(bus.in_data));
                  mdl[nbeats] = bus.in_data;
               end else begin
                  viol++;
               end
               last_hs = cyc;
               nbeats++;
            end
         end
         if (done) done_cyc = cyc;
      end
      @(negedge clk);
      save_start = 1'b0; restore_start = 1'b0;
      bus.out_ready = 1'b0; bus.in_valid = 1'b0; bus.rf_err = 1'b0;
      #1;
      if (done || busy || bus.out_valid || bus.in_ready || bus.writeEn) viol++;
      if (bus.read1RegSel != 3'd0 || bus.read2RegSel != 3'd0) viol++;
   endtask

   initial begin
      int   nb, dc, lh, vi;
      logic e1;

      bus.out_ready = 1'b0; bus.in_valid = 1'b0; bus.in_data = 16'd0; bus.rf_err = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_wr", {bus.writeEn, bus.writeRegSel, bus.writeData}, 32'd0);
      check("rst_sels", {bus.read1RegSel, bus.read2RegSel}, 32'd0);
      check("rst_out_data", bus.out_data, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // directed save with ready always high
      preload(1);
      run_op(1, 0, 100, 0, 0, 0, nb, dc, lh, vi, e1);
      check("save_beats", 32'(nb), 32'd4);
      check("save_done_cyc", 32'(dc), 32'd9);
      check("save_viol", 32'(vi), 32'd0);
      check("save_err", 32'(err), 32'd0);

      // save with beat 1 stalled for five cycles
      run_op(1, 0, 100, 0, 0, 5, nb, dc, lh, vi, e1);
      check("stall_beats", 32'(nb), 32'd4);
      check("stall_done_cyc", 32'(dc), 32'd14);
      check("stall_viol", 32'(vi), 32'd0);

      // simultaneous start: save wins
      preload(0);
      run_op(1, 1, 70, 0, 0, 0, nb, dc, lh, vi, e1);
      check("both_beats", 32'(nb), 32'd4);
      check("both_viol", 32'(vi), 32'd0);

      // random saves
      for (int r = 0; r < 5; r++) begin
         preload(0);
         run_op(1, 0, 50, 0, 0, 0, nb, dc, lh, vi, e1);
         check("rsave_beats", 32'(nb), 32'd4);
         check("rsave_done", 32'(dc), 32'(lh + 1));
         check("rsave_viol", 32'(vi), 32'd0);
      end

      // directed restore, one beat per cycle
      preload(1);
      run_op(0, 1, 100, 0, 1, 0, nb, dc, lh, vi, e1);
      check("rest_beats", 32'(nb), 32'd8);
      check("rest_done_cyc", 32'(dc), 32'd9);
      check("rest_viol", 32'(vi), 32'd0);
      for (int i = 0; i < NREGS; i++) check("rest_rf", 32'(rf[i]), 32'(32'hA000 + i));

      // random restores
      for (int r = 0; r < 5; r++) begin
         run_op(0, 1, 60, 0, 0, 0, nb, dc, lh, vi, e1);
         check("rrest_beats", 32'(nb), 32'd8);
         check("rrest_done", 32'(dc), 32'(lh + 1));
         check("rrest_viol", 32'(vi), 32'd0);
         for (int i = 0; i < NREGS; i++) check("rrest_rf", 32'(rf[i]), 32'(mdl[i]));
      end

      // rf_err during restore beat 3
      preload(1);
      run_op(0, 1, 100, 4, 1, 0, nb, dc, lh, vi, e1);
      check("abort_beats", 32'(nb), 32'd3);
      check("abort_done_cyc", 32'(dc), 32'd5);
      check("abort_viol", 32'(vi), 32'd0);
      check("abort_err", 32'(err), 32'd1);
      check("abort_r2", 32'(rf[2]), 32'hA002);
      check("abort_r3", 32'(rf[3]), 32'h1003);
      repeat (2) @(negedge clk);
      #1;
      check("err_sticky", 32'(err), 32'd1);
      run_op(1, 0, 100, 0, 0, 0, nb, dc, lh, vi, e1);
      check("err_cleared", 32'(e1), 32'd0);
      check("after_abort_beats", 32'(nb), 32'd4);

      // reset while in S_SEND
      preload(0);
      @(negedge clk);
      save_start = 1'b1; bus.out_ready = 1'b0;
      @(negedge clk);
      save_start = 1'b0;
      @(negedge clk);
      #1;
      check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("in_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_valid", 32'(bus.out_valid), 32'd0);
      check("post_rst_done", 32'(done), 32'd0);
      vi = 0;
      repeat (3) begin
         @(negedge clk);
         #1;
         if (done || busy) vi++;
      end
      check("post_rst_idle", 32'(vi), 32'd0);
      run_op(1, 0, 100, 0, 0, 0, nb, dc, lh, vi, e1);
      check("post_rst_beats", 32'(nb), 32'd4);
      check("post_rst_done_cyc", 32'(dc), 32'd9);
      check("post_rst_viol", 32'(vi), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
